// File: rtl/ks_subtractor_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ks_subtractor_pipe : 3-stage Kogge-Stone subtractor, valid/ready, flags   |
// | Optional clamp on signed overflow: KS_SUB_SATURATE_EN     Rev 1.0         |
// +--------------------------------------------------------------------------+
module ks_subtractor_pipe #(
  parameter int WIDTH = 64,
  parameter int SPLIT = $clog2(WIDTH) / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int LEVELS = $clog2(WIDTH);

  logic             adv;

  logic             v1_q, v1_d;
  logic [WIDTH-1:0] a1_q, a1_d;
  logic [WIDTH-1:0] nb1_q, nb1_d;
  logic             c01_q, c01_d;

  logic             v2_q, v2_d;
  logic [WIDTH-1:0] g2_q, g2_d;
  logic [WIDTH-1:0] p2_q, p2_d;
  logic [WIDTH-1:0] p02_q, p02_d;
  logic             c02_q, c02_d;
  logic             amsb2_q, amsb2_d;
  logic             bmsb2_q, bmsb2_d;

  logic             v3_q, v3_d;
  logic [WIDTH-1:0] diff3_q, diff3_d;
  logic             bout3_q, bout3_d;
  logic             zero3_q, zero3_d;
  logic             neg3_q, neg3_d;
  logic             ovf3_q, ovf3_d;

  logic [WIDTH-1:0] p0_s1, g_pre, p_pre;
  logic [WIDTH-1:0] g_fin, p_fin, carry, diff_raw, diff_fin;
  logic             ovf_raw;

  // One shared enable: the whole pipe moves or the whole pipe holds.
  assign adv       = ~v3_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign diff      = diff3_q;
  assign bout      = bout3_q;
  assign zero      = zero3_q;
  assign neg       = neg3_q;
  assign ovf       = ovf3_q;

  always_comb begin
    v1_d  = in_valid;
    a1_d  = a;
    nb1_d = ~b;
    c01_d = ~bin;
  end

  // Carry-in is folded into bit 0's generate so the prefix tree yields carries directly.
  always_comb begin
    p0_s1    = a1_q ^ nb1_q;
    g_pre    = a1_q & nb1_q;
    g_pre[0] = g_pre[0] | (p0_s1[0] & c01_q);
    p_pre    = p0_s1;
    for (int l = 0; l < SPLIT; l++) begin
      g_pre = g_pre | (p_pre & (g_pre << (2 ** l)));
      p_pre = p_pre & ((p_pre << (2 ** l)) | ~({WIDTH{1'b1}} << (2 ** l)));
    end
    v2_d    = v1_q;
    g2_d    = g_pre;
    p2_d    = p_pre;
    p02_d   = p0_s1;
    c02_d   = c01_q;
    amsb2_d = a1_q[WIDTH-1];
    bmsb2_d = ~nb1_q[WIDTH-1];
  end

  always_comb begin
    g_fin = g2_q;
    p_fin = p2_q;
    for (int l = SPLIT; l < LEVELS; l++) begin
      g_fin = g_fin | (p_fin & (g_fin << (2 ** l)));
      p_fin = p_fin & ((p_fin << (2 ** l)) | ~({WIDTH{1'b1}} << (2 ** l)));
    end
    carry    = {g_fin[WIDTH-2:0], c02_q};
    diff_raw = p02_q ^ carry;
    ovf_raw  = (amsb2_q != bmsb2_q) && (diff_raw[WIDTH-1] != amsb2_q);
`ifdef KS_SUB_SATURATE_EN
    if (ovf_raw) begin
      diff_fin = amsb2_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      diff_fin = diff_raw;
    end
`else
    diff_fin = diff_raw;
`endif
    v3_d    = v2_q;
    diff3_d = diff_fin;
    bout3_d = ~g_fin[WIDTH-1];
    zero3_d = (diff_fin == '0);
    neg3_d  = diff_fin[WIDTH-1];
    ovf3_d  = ovf_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      nb1_q   <= '0;
      c01_q   <= 1'b0;
      v2_q    <= 1'b0;
      g2_q    <= '0;
      p2_q    <= '0;
      p02_q   <= '0;
      c02_q   <= 1'b0;
      amsb2_q <= 1'b0;
      bmsb2_q <= 1'b0;
      v3_q    <= 1'b0;
      diff3_q <= '0;
      bout3_q <= 1'b0;
      zero3_q <= 1'b0;
      neg3_q  <= 1'b0;
      ovf3_q  <= 1'b0;
    end else if (adv) begin
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      nb1_q   <= nb1_d;
      c01_q   <= c01_d;
      v2_q    <= v2_d;
      g2_q    <= g2_d;
      p2_q    <= p2_d;
      p02_q   <= p02_d;
      c02_q   <= c02_d;
      amsb2_q <= amsb2_d;
      bmsb2_q <= bmsb2_d;
      v3_q    <= v3_d;
      diff3_q <= diff3_d;
      bout3_q <= bout3_d;
      zero3_q <= zero3_d;
      neg3_q  <= neg3_d;
      ovf3_q  <= ovf3_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ks_subtractor_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ks_subtractor_pipe : directed + scoreboard bench for ks_subtractor_pipe|
// +--------------------------------------------------------------------------+
module tb_ks_subtractor_pipe;

  localparam int W  = 64;
  localparam int CW = W + 4;
  typedef logic [CW-1:0] cmp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic         neg;
  logic         ovf;

  cmp_t res;
  assign res = {diff, bout, zero, neg, ovf};

  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   n_out = 0;
  cmp_t exp_q[$];
  logic hold_vld = 1'b0;
  cmp_t hold_val;

  ks_subtractor_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input cmp_t got, input cmp_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 65-bit arithmetic, result packed as {diff, bout, zero, neg, ovf}.
  function automatic cmp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [W:0]   r;
    logic [W-1:0] d;
    logic         o;
    r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    d = r[W-1:0];
    o = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
`ifdef KS_SUB_SATURATE_EN
    if (o) d = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {d, r[W], (d == '0), d[W-1], o};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        check("hold_valid", cmp_t'(out_valid), cmp_t'(1));
        check("hold_data", res, hold_val);
      end
      if (out_valid && !out_ready) begin
        check("in_ready_stall", cmp_t'(in_ready), cmp_t'(0));
        hold_vld = 1'b1;
        hold_val = res;
      end else begin
        hold_vld = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("spurious_out_valid", cmp_t'(out_valid), cmp_t'(0));
        else check("result", res, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        n_acc++;
        exp_q.push_back(model(a, b, bin));
      end
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    int t;
    a = x; b = y; bin = bi; in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    if (!in_ready) check("send_timeout", cmp_t'(in_ready), cmp_t'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // k counts register edges starting with the accepting one.
  task automatic expect_beat(input string tag, input cmp_t exp_res);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 8);
    check({tag, "_lat"}, cmp_t'(k), cmp_t'(3));
    check({tag, "_res"}, res, exp_res);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    int start;
    int cyc;
    logic [W-1:0] ra;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", cmp_t'(out_valid), cmp_t'(0));
    check("rst_data", res, cmp_t'(0));
    check("rst_in_ready", cmp_t'(in_ready), cmp_t'(1));
    @(posedge clk); #1;

    send(64'd5, 64'd3, 1'b0);
    expect_beat("basic", {64'h2, 4'b0000});
    send(64'd0, 64'd0, 1'b1);
    expect_beat("borrow_chain", {64'hFFFF_FFFF_FFFF_FFFF, 4'b1010});
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0);
`ifdef KS_SUB_SATURATE_EN
    expect_beat("ovf_neg", {64'h8000_0000_0000_0000, 4'b0011});
`else
    expect_beat("ovf_neg", {64'h7FFF_FFFF_FFFF_FFFF, 4'b0001});
`endif
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
`ifdef KS_SUB_SATURATE_EN
    expect_beat("ovf_pos", {64'h7FFF_FFFF_FFFF_FFFF, 4'b1001});
`else
    expect_beat("ovf_pos", {64'h8000_0000_0000_0000, 4'b1011});
`endif
    send(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    expect_beat("equal", {64'h0, 4'b0100});

    // Back-to-back stream with the consumer stalled during cycles 4-8.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      end
      begin
        for (int c = 1; c <= 20; c++) begin
          out_ready = !(c >= 4 && c <= 8);
          @(posedge clk); #1;
        end
      end
    join
    repeat (5) @(negedge clk);
    check("bp_count", cmp_t'(n_out - n0), cmp_t'(10));
    check("bp_drain", cmp_t'(exp_q.size()), cmp_t'(0));
    @(posedge clk); #1;

    // Fill the pipe, then reset it.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", cmp_t'(out_valid), cmp_t'(0));
    check("mid_rst_data", res, cmp_t'(0));
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no_stale", cmp_t'(out_valid), cmp_t'(0));
    end
    @(posedge clk); #1;
    send(64'd7, 64'd7, 1'b0);
    expect_beat("post_rst", {64'h0, 4'b0100});

    // Random regression with random source and sink pacing.
    start = n_acc;
    cyc   = 0;
    while ((n_acc - start) < 10000 && cyc < 60000) begin
      ra        = ($urandom_range(0, 7) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
      a         = ra;
      b         = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
      bin       = 1'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("regress_beats", cmp_t'(n_acc - start), cmp_t'(10000));
    repeat (10) @(negedge clk);
    check("final_drain", cmp_t'(exp_q.size()), cmp_t'(0));
    check("final_count", cmp_t'(n_out), cmp_t'(n_acc - 3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
